// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the Execute-stage issue/retire sequencer.
//   seqState_t : sequencer FSM states
//   ALU_*      : opcodes the sequencer recognises (only ALU_DIV changes routing)
//   N/Z/V/C    : bit positions inside the 4-bit flag vector {N,Z,V,C}
package exec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DIV  = 2'd2,
        HOLD = 2'd3
    } seqState_t;

    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_DIV  = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b0111;
    localparam logic [3:0] ALU_VADD = 4'b1100;
    localparam logic [3:0] ALU_VSUB = 4'b1101;

    localparam int unsigned N = 3;
    localparam int unsigned Z = 2;
    localparam int unsigned V = 1;
    localparam int unsigned C = 0;

    // Place individual flags at their architectural bit positions.
    function automatic logic [3:0] packFlags(input logic n, input logic z,
                                             input logic v, input logic c);
        logic [3:0] f;
        f    = 4'b0000;
        f[N] = n;
        f[Z] = z;
        f[V] = v;
        f[C] = c;
        return f;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Decode-issue and writeback-retire channels of the Execute sequencer.
//   master : environment side (decode drives operands, writeback drives outReady)
//   slave  : sequencer side (drives inReady and the result channel)
interface exec_sequencer_if
    import exec_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 19,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned TAG_WIDTH   = 5
);
    logic                          inValid;
    logic                          inReady;
    logic [3:0]                    inAluControl;
    logic                          inUseInmediate;
    logic                          inUseScalarAlu;
    logic                          inIsScalarReg2;
    logic [DATA_WIDTH-1:0]         inScalarData1;
    logic [DATA_WIDTH-1:0]         inScalarData2;
    logic [DATA_WIDTH-1:0]         inScalarInmediate;
    logic [VECTOR_SIZE*WIDTH-1:0]  inVectorOperand1;
    logic [VECTOR_SIZE*WIDTH-1:0]  inVectorOperand2;
    logic [TAG_WIDTH-1:0]          inDestTag;

    logic                          outValid;
    logic                          outReady;
    logic [63:0]                   outData;
    logic [3:0]                    outFlags;
    logic [TAG_WIDTH-1:0]          outDestTag;

    modport master (
        output inValid, inAluControl, inUseInmediate, inUseScalarAlu, inIsScalarReg2,
               inScalarData1, inScalarData2, inScalarInmediate,
               inVectorOperand1, inVectorOperand2, inDestTag, outReady,
        input  inReady, outValid, outData, outFlags, outDestTag
    );

    modport slave (
        input  inValid, inAluControl, inUseInmediate, inUseScalarAlu, inIsScalarReg2,
               inScalarData1, inScalarData2, inScalarInmediate,
               inVectorOperand1, inVectorOperand2, inDestTag, outReady,
        output inReady, outValid, outData, outFlags, outDestTag
    );

endinterface

// File: rtl/iterative_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   start/abort         : load operands / cancel the running division
//   dividend/divisor    : sampled on start
//   done                : high in the cycle whose edge produces the final bit
//   quotient/remainder  : result of the current step (final when done)
//   divByZero           : divisor sampled on start was zero (no iteration runs)
module iterative_divider #(
    parameter int unsigned DATA_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic                  divByZero,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  active;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] quoReg;
    logic [DATA_WIDTH-1:0] remReg;
    logic [DATA_WIDTH-1:0] divisorReg;
    logic                  dbzReg;

    logic [DATA_WIDTH:0]   remShift;
    logic                  fits;
    logic [DATA_WIDTH-1:0] remNext;
    logic [DATA_WIDTH-1:0] quoNext;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        remShift = {remReg, quoReg[DATA_WIDTH-1]};
        fits     = (remShift >= {1'b0, divisorReg});
        remNext  = fits ? DATA_WIDTH'(remShift - {1'b0, divisorReg})
                        : remShift[DATA_WIDTH-1:0];
        quoNext  = {quoReg[DATA_WIDTH-2:0], fits};
    end

    assign done      = active && (count == '0);
    assign quotient  = quoNext;
    assign remainder = remNext;
    assign divByZero = dbzReg;

    // Quotient bits are shifted into the low end of the dividend register.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            active     <= 1'b0;
            count      <= '0;
            quoReg     <= '0;
            remReg     <= '0;
            divisorReg <= '0;
            dbzReg     <= 1'b0;
        end else if (start) begin
            active     <= (divisor != '0);
            count      <= CNT_W'(DATA_WIDTH - 1);
            quoReg     <= dividend;
            remReg     <= '0;
            divisorReg <= divisor;
            dbzReg     <= (divisor == '0);
        end else if (active) begin
            quoReg <= quoNext;
            remReg <= remNext;
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Issue/retire controller in front of the vector Execute stage.
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : decode issue handshake and writeback result handshake
//   flush          : abort the in-flight operation
//   ex*            : registered operands driven to the combinational Execute datapath
//   exOut, exN..C  : Execute result and flags
//   busy           : sequencer not idle
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 19,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned TAG_WIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    exec_sequencer_if.slave              bus,
    input  logic                         flush,
    output logic [3:0]                   exAluControl,
    output logic                         exUseInmediate,
    output logic                         exUseScalarAlu,
    output logic                         exIsScalarReg2,
    output logic [DATA_WIDTH-1:0]        exScalarData1,
    output logic [DATA_WIDTH-1:0]        exScalarData2,
    output logic [DATA_WIDTH-1:0]        exScalarInmediate,
    output logic [VECTOR_SIZE*WIDTH-1:0] exVectorOperand1,
    output logic [VECTOR_SIZE*WIDTH-1:0] exVectorOperand2,
    input  logic [63:0]                  exOut,
    input  logic                         exN,
    input  logic                         exZ,
    input  logic                         exV,
    input  logic                         exC,
    output logic                         busy
);
    seqState_t             state;
    seqState_t             stateNext;
    logic                  accept;
    logic                  divStart;
    logic                  captureExec;
    logic                  captureDiv;
    logic                  captureDbz;
    logic                  retire;

    logic                  divDone;
    logic                  divByZero;
    logic [DATA_WIDTH-1:0] divQuotient;
    logic [DATA_WIDTH-1:0] unusedRemainder;
    logic [DATA_WIDTH-1:0] divDivisor;

    assign bus.inReady = (state == IDLE) && rst_n;
    assign busy        = (state != IDLE);

    // The divider loads at the accept edge, so it takes the operands straight
    // from decode; these are the same values the ex* registers capture.
    assign divDivisor = bus.inUseInmediate ? bus.inScalarInmediate : bus.inScalarData2;

    iterative_divider #(.DATA_WIDTH(DATA_WIDTH)) uDivider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (divStart),
        .abort     (flush),
        .dividend  (bus.inScalarData1),
        .divisor   (divDivisor),
        .done      (divDone),
        .divByZero (divByZero),
        .quotient  (divQuotient),
        .remainder (unusedRemainder)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and step strobes; flush overrides every handshake.
    always_comb begin
        stateNext   = state;
        accept      = 1'b0;
        divStart    = 1'b0;
        captureExec = 1'b0;
        captureDiv  = 1'b0;
        captureDbz  = 1'b0;
        retire      = 1'b0;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        accept = 1'b1;
                        if (bus.inUseScalarAlu && (bus.inAluControl == ALU_DIV)) begin
                            divStart  = 1'b1;
                            stateNext = DIV;
                        end else begin
                            stateNext = EXEC;
                        end
                    end
                end
                EXEC: begin
                    captureExec = 1'b1;
                    stateNext   = HOLD;
                end
                DIV: begin
                    if (divByZero) begin
                        captureDbz = 1'b1;
                        stateNext  = HOLD;
                    end else if (divDone) begin
                        captureDiv = 1'b1;
                        stateNext  = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.outReady) begin
                        retire    = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Operand registers to Execute; they keep their value until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exAluControl      <= '0;
            exUseInmediate    <= 1'b0;
            exUseScalarAlu    <= 1'b0;
            exIsScalarReg2    <= 1'b0;
            exScalarData1     <= '0;
            exScalarData2     <= '0;
            exScalarInmediate <= '0;
            exVectorOperand1  <= '0;
            exVectorOperand2  <= '0;
        end else if (accept) begin
            exAluControl      <= bus.inAluControl;
            exUseInmediate    <= bus.inUseInmediate;
            exUseScalarAlu    <= bus.inUseScalarAlu;
            exIsScalarReg2    <= bus.inIsScalarReg2;
            exScalarData1     <= bus.inScalarData1;
            exScalarData2     <= bus.inScalarData2;
            exScalarInmediate <= bus.inScalarInmediate;
            exVectorOperand1  <= bus.inVectorOperand1;
            exVectorOperand2  <= bus.inVectorOperand2;
        end
    end

    // Result channel; Execute's result is passed through untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.outValid   <= 1'b0;
            bus.outData    <= '0;
            bus.outFlags   <= '0;
            bus.outDestTag <= '0;
        end else begin
            if (accept) begin
                bus.outDestTag <= bus.inDestTag;
            end
            if (captureExec) begin
                bus.outData  <= exOut;
                bus.outFlags <= packFlags(exN, exZ, exV, exC);
                bus.outValid <= 1'b1;
            end else if (captureDbz) begin
                bus.outData  <= 64'({DATA_WIDTH{1'b1}});
                bus.outFlags <= packFlags(1'b0, 1'b0, 1'b1, 1'b0);
                bus.outValid <= 1'b1;
            end else if (captureDiv) begin
                bus.outData  <= 64'(divQuotient);
                bus.outFlags <= packFlags(1'b0, (divQuotient == '0), 1'b0, 1'b0);
                bus.outValid <= 1'b1;
            end else if (retire || flush) begin
                bus.outValid <= 1'b0;
            end
        end
    end

endmodule
